// File: rtl/fp_pkg.sv
// Shared types and defaults for the floating-point register file slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package fp_pkg;

  localparam int unsigned FLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   freg_addr_t;
  typedef logic [FLEN_DEF-1:0] freg_data_t;

  // One register-file write port: strobe, destination and payload.
  typedef struct packed {
    logic       we;
    freg_addr_t addr;
    freg_data_t data;
  } fp_wport_t;

endpackage

// File: rtl/fp_scoreboard.sv
// Busy-bit scoreboard for in-flight multi-cycle FPU ops, with issue stall generation.
// Latency: stall/fire combinational; busy set/clear registered at the next edge.
// Backpressure: iss_stall_o holds issue while a source or destination is pending.
module fp_scoreboard
  import fp_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 3,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    iss_valid_i,
  input  logic [AW-1:0]           iss_rd_i,
  input  logic [NRD-1:0]          iss_rs_used_i,
  input  logic [NRD-1:0][AW-1:0]  rd_addr_i,
  input  logic                    clr_i,
  input  logic [AW-1:0]           clr_addr_i,
  output logic                    iss_stall_o,
  output logic                    iss_fire_o,
  output logic [NREGS-1:0]        busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] busy_eff;
  logic             hazard;

  // Clear-bypassed busy view, hazard check, and next busy state (set beats clear).
  always_comb begin
    busy_eff = busy_q;
    if (clr_i) begin
      busy_eff[clr_addr_i] = 1'b0;
    end
    hazard = busy_eff[iss_rd_i];
    for (int k = 0; k < NRD; k++) begin
      if (iss_rs_used_i[k] && busy_eff[rd_addr_i[k]]) begin
        hazard = 1'b1;
      end
    end
    iss_stall_o = iss_valid_i & hazard;
    iss_fire_o  = iss_valid_i & ~hazard;
    busy_d      = busy_eff;
    if (iss_fire_o) begin
      busy_d[iss_rd_i] = 1'b1;
    end
  end

  // Busy vector register; reset forgets every in-flight op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file: NRD combinational reads, two prioritised write ports, optional bypass, scoreboard.
// Latency: reads 0 cycles, writes visible after 1 edge (same cycle when bypassed).
// Backpressure: iss_stall_o blocks issue on busy operands; dropped/WAW port-B writes flagged a cycle later.
module fp_regfile_sb
  import fp_pkg::*;
#(
  parameter int unsigned FLEN   = FLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 3,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][FLEN-1:0] rd_data_o,
  input  logic                     fpu_we_i,
  input  logic [AW-1:0]            fpu_waddr_i,
  input  logic [FLEN-1:0]          fpu_wdata_i,
  input  logic                     mv_we_i,
  input  logic [AW-1:0]            mv_waddr_i,
  input  logic [FLEN-1:0]          mv_wdata_i,
  input  logic                     iss_valid_i,
  input  logic [AW-1:0]            iss_rd_i,
  input  logic [NRD-1:0]           iss_rs_used_i,
  output logic                     iss_stall_o,
  output logic                     iss_fire_o,
  output logic [NREGS-1:0]         busy_o,
  output logic                     wr_conflict_o
);

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [FLEN-1:0] data;
  } wport_t;

  wport_t                     port_a, port_b;
  logic [NREGS-1:0][FLEN-1:0] regs_q, regs_d;
  logic                       wr_conflict_q, wr_conflict_d;
  logic                       b_drop, b_waw;

  assign port_a = '{we: fpu_we_i, addr: fpu_waddr_i, data: fpu_wdata_i};
  assign port_b = '{we: mv_we_i,  addr: mv_waddr_i,  data: mv_wdata_i};

  // Port B loses to port A on the same address; a write into a pending destination is a WAW.
  always_comb begin
    b_drop        = port_b.we & port_a.we & (port_b.addr == port_a.addr);
    b_waw         = port_b.we & busy_o[port_b.addr];
    wr_conflict_d = b_drop | b_waw;
  end

  // Next storage state: B first so A overrides it on a shared address.
  always_comb begin
    regs_d = regs_q;
    if (port_b.we && !b_drop) begin
      regs_d[port_b.addr] = port_b.data;
    end
    if (port_a.we) begin
      regs_d[port_a.addr] = port_a.data;
    end
  end

  // Storage and conflict pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict_o = wr_conflict_q;

  // Read muxes: optional forwarding of this cycle's writes, port A taking precedence.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_data_o[k] = regs_q[rd_addr_i[k]];
      if (BYPASS) begin
        if (port_a.we && (port_a.addr == rd_addr_i[k])) begin
          rd_data_o[k] = port_a.data;
        end else if (port_b.we && (port_b.addr == rd_addr_i[k])) begin
          rd_data_o[k] = port_b.data;
        end
      end
    end
  end

  fp_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .iss_valid_i   (iss_valid_i),
    .iss_rd_i      (iss_rd_i),
    .iss_rs_used_i (iss_rs_used_i),
    .rd_addr_i     (rd_addr_i),
    .clr_i         (fpu_we_i),
    .clr_addr_i    (fpu_waddr_i),
    .iss_stall_o   (iss_stall_o),
    .iss_fire_o    (iss_fire_o),
    .busy_o        (busy_o)
  );

endmodule

// File: tb/tb_fp_regfile_sb.sv
module tb_fp_regfile_sb;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic [2:0][4:0] rd_addr;
  logic [2:0][31:0] rd_data_b, rd_data_n;
  logic            fpu_we, mv_we, iss_valid;
  logic [4:0]      fpu_waddr, mv_waddr, iss_rd;
  logic [31:0]     fpu_wdata, mv_wdata;
  logic [2:0]      iss_used;
  logic            stall_b, fire_b, conf_b, stall_n, fire_n, conf_n;
  logic [31:0]     busy_b, busy_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rb [3];
    logic [31:0] rn [3];
    logic        stall;
    logic        fire;
    logic        conf;
    logic [31:0] busy;
  } exp_t;

  exp_t        expq [$];
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_conf;

  always #5 clk_i = ~clk_i;

  fp_regfile_sb #(.FLEN(32), .NREGS(32), .NRD(3), .BYPASS(1'b1)) dut_byp (
    .clk_i(clk_i), .rst_ni(rst_ni), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .fpu_we_i(fpu_we), .fpu_waddr_i(fpu_waddr), .fpu_wdata_i(fpu_wdata),
    .mv_we_i(mv_we), .mv_waddr_i(mv_waddr), .mv_wdata_i(mv_wdata),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_rs_used_i(iss_used),
    .iss_stall_o(stall_b), .iss_fire_o(fire_b), .busy_o(busy_b), .wr_conflict_o(conf_b)
  );

  fp_regfile_sb #(.FLEN(32), .NREGS(32), .NRD(3), .BYPASS(1'b0)) dut_nobyp (
    .clk_i(clk_i), .rst_ni(rst_ni), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
    .fpu_we_i(fpu_we), .fpu_waddr_i(fpu_waddr), .fpu_wdata_i(fpu_wdata),
    .mv_we_i(mv_we), .mv_waddr_i(mv_waddr), .mv_wdata_i(mv_wdata),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_rs_used_i(iss_used),
    .iss_stall_o(stall_n), .iss_fire_o(fire_n), .busy_o(busy_n), .wr_conflict_o(conf_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
    m_conf = 1'b0;
  endtask

  task automatic idle();
    fpu_we = 0; fpu_waddr = 0; fpu_wdata = 0;
    mv_we = 0; mv_waddr = 0; mv_wdata = 0;
    iss_valid = 0; iss_rd = 0; iss_used = 0;
  endtask

  // Build the expected response for the current inputs, then advance the model across the edge.
  task automatic step();
    exp_t        e;
    logic [31:0] pend;
    logic        hz;
    pend = m_busy;
    if (fpu_we) pend[fpu_waddr] = 1'b0;
    hz = pend[iss_rd];
    for (int k = 0; k < 3; k++)
      if (iss_used[k] && pend[rd_addr[k]]) hz = 1'b1;
    e.stall = iss_valid && hz;
    e.fire  = iss_valid && !hz;
    e.busy  = m_busy;
    e.conf  = m_conf;
    for (int k = 0; k < 3; k++) begin
      e.rn[k] = m_mem[rd_addr[k]];
      if (fpu_we && fpu_waddr == rd_addr[k])      e.rb[k] = fpu_wdata;
      else if (mv_we && mv_waddr == rd_addr[k])   e.rb[k] = mv_wdata;
      else                                        e.rb[k] = e.rn[k];
    end
    expq.push_back(e);
    @(posedge clk_i);
    m_conf = mv_we && ((fpu_we && fpu_waddr == mv_waddr) || m_busy[mv_waddr]);
    if (mv_we && !(fpu_we && fpu_waddr == mv_waddr)) m_mem[mv_waddr] = mv_wdata;
    if (fpu_we) m_mem[fpu_waddr] = fpu_wdata;
    m_busy = pend;
    if (e.fire) m_busy[iss_rd] = 1'b1;
    #1;
  endtask

  // Monitor: compare the outstanding expectation once outputs have settled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("rd_byp[%0d]", k), rd_data_b[k], e.rb[k]);
          chk($sformatf("rd_nobyp[%0d]", k), rd_data_n[k], e.rn[k]);
        end
        chk("stall", {31'b0, stall_b}, {31'b0, e.stall});
        chk("fire", {31'b0, fire_b}, {31'b0, e.fire});
        chk("busy", busy_b, e.busy);
        chk("wr_conflict", {31'b0, conf_b}, {31'b0, e.conf});
        chk("busy_nobyp", busy_n, e.busy);
        chk("wr_conflict_nobyp", {31'b0, conf_n}, {31'b0, e.conf});
      end
    end
  end

  initial begin
    idle();
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd5; rd_addr[2] = 5'd31;
    model_reset();
    #1 rst_ni = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_rd[%0d]", k), rd_data_b[k], 32'h0);
    chk("reset_busy", busy_b, 32'h0);
    chk("reset_conflict", {31'b0, conf_b}, 32'h0);
    @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reads of 0, 5, 31 after reset, then a port-A write to f5 read back.
    step();
    fpu_we = 1; fpu_waddr = 5; fpu_wdata = 32'h3F80_0000; step();
    idle(); step();

    // Same-address A/B collision, then a clean cycle, then different addresses.
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd1; rd_addr[2] = 5'd2;
    fpu_we = 1; fpu_waddr = 3; fpu_wdata = 32'h4000_0000;
    mv_we = 1; mv_waddr = 3; mv_wdata = 32'h4040_0000; step();
    idle(); step();
    fpu_we = 1; fpu_waddr = 1; fpu_wdata = 32'h1111_1111;
    mv_we = 1; mv_waddr = 2; mv_wdata = 32'h2222_2222; step();
    idle(); step();

    // Port-B write to f7 while reading f7.
    rd_addr[0] = 5'd7;
    mv_we = 1; mv_waddr = 7; mv_wdata = 32'hC000_0000; step();
    idle(); step();

    // Issue to f4, dependant stalls, then issues alongside f4's writeback.
    iss_valid = 1; iss_rd = 4; step();
    idle(); rd_addr[0] = 5'd4; iss_valid = 1; iss_rd = 4; iss_used = 3'b001; step();
    fpu_we = 1; fpu_waddr = 4; fpu_wdata = 32'h4080_0000; step();

    // Fire to f9 with a same-cycle clear of f9, then a WAW port-B write to f9.
    idle(); iss_valid = 1; iss_rd = 9;
    fpu_we = 1; fpu_waddr = 9; fpu_wdata = 32'h0000_0009; step();
    idle(); rd_addr[1] = 5'd9; mv_we = 1; mv_waddr = 9; mv_wdata = 32'hDEAD_BEEF; step();
    idle(); step();
    chk("busy_before_reset", busy_b, 32'h0000_0210);

    // Asynchronous reset in the middle of a cycle with state outstanding.
    rd_addr[0] = 5'd4; rd_addr[1] = 5'd9; rd_addr[2] = 5'd5;
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_busy", busy_b, 32'h0);
    for (int k = 0; k < 3; k++) chk($sformatf("midrst_rd[%0d]", k), rd_data_b[k], 32'h0);
    model_reset();
    @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    step();
    fpu_we = 1; fpu_waddr = 4; fpu_wdata = 32'h5555_AAAA; step();
    idle(); step();

    // Randomised traffic over a narrow address range to provoke hazards and collisions.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) rd_addr[k] = 5'($urandom_range(0, 7));
      fpu_we    = ($urandom_range(0, 99) < 40);
      fpu_waddr = 5'($urandom_range(0, 7));
      fpu_wdata = $urandom;
      mv_we     = ($urandom_range(0, 99) < 40);
      mv_waddr  = 5'($urandom_range(0, 7));
      mv_wdata  = $urandom;
      iss_valid = ($urandom_range(0, 99) < 50);
      iss_rd    = 5'($urandom_range(0, 7));
      iss_used  = 3'($urandom_range(0, 7));
      step();
    end
    idle(); step();
    @(negedge clk_i); #1;
    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
